// File: rtl/alu_if.sv
// ---------------------------------------------------------------------------
// alu_if: operand/result bundle for the registered ALU.
//
// Handshake: in_valid qualifies a, b and opcode (and fault_en/fault_bit when
// built with ALU_FAULT_INJECT_EN) for one rising clk edge. out_valid is high
// for exactly one cycle per accepted input, one cycle later. There is no
// ready/backpressure: the consumer must take every out_valid pulse.
//
// Signals:
//   in_valid, a, b, opcode      : producer -> ALU
//   out_valid, result, flag_*   : ALU -> consumer (registered)
//   fault_en, fault_bit         : producer -> ALU, only with ALU_FAULT_INJECT_EN
//
// Modports: master = operand producer / result consumer, slave = ALU.
// ---------------------------------------------------------------------------
interface alu_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       opcode;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_neg;
    logic             flag_carry;
    logic             flag_ovf;
`ifdef ALU_FAULT_INJECT_EN
    logic               fault_en;
    logic [SHAMT_W-1:0] fault_bit;

    modport master (
        output in_valid, a, b, opcode, fault_en, fault_bit,
        input  out_valid, result, flag_zero, flag_neg, flag_carry, flag_ovf
    );
    modport slave (
        input  in_valid, a, b, opcode, fault_en, fault_bit,
        output out_valid, result, flag_zero, flag_neg, flag_carry, flag_ovf
    );
`else
    modport master (
        output in_valid, a, b, opcode,
        input  out_valid, result, flag_zero, flag_neg, flag_carry, flag_ovf
    );
    modport slave (
        input  in_valid, a, b, opcode,
        output out_valid, result, flag_zero, flag_neg, flag_carry, flag_ovf
    );
`endif
endinterface

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu: 32-bit registered arithmetic/logic unit, one operation per accepted
// input, single-cycle latency, full throughput.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears result, flags, out_valid
//   bus    : alu_if.slave (in_valid/a/b/opcode in; out_valid/result/flags out)
//
// Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT.
// flag_carry/flag_ovf are meaningful for ADD/SUB only and 0 otherwise.
// On idle cycles (in_valid=0) out_valid drops and result/flags hold.
//
// Build option ALU_FAULT_INJECT_EN: adds bus.fault_en/bus.fault_bit. An
// accepted op with fault_en=1 flips result bit fault_bit; zero/neg follow the
// corrupted result, carry/ovf keep the true values.
// ---------------------------------------------------------------------------
module alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input logic clk,
    input logic rst_n,
    alu_if.slave bus
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_SLT = 3'd7
    } op_e;

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_lt;
    logic [WIDTH-1:0]   w_result;
    logic               w_carry;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_final;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_neg;
    logic               r_carry;
    logic               r_ovf;

    // Extended by one bit so the top bit is the ADD carry / SUB borrow.
    assign w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff  = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_shamt = bus.b[SHAMT_W-1:0];
    assign w_lt    = $signed(bus.a) < $signed(bus.b);

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (op_e'(bus.opcode))
            OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
                // Same-sign operands producing a different-sign sum.
                w_ovf    = (bus.a[MSB] == bus.b[MSB]) && (w_sum[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                w_result = w_diff[WIDTH-1:0];
                w_carry  = w_diff[WIDTH];
                // Opposite-sign operands and the difference sign differs from a.
                w_ovf    = (bus.a[MSB] != bus.b[MSB]) && (w_diff[MSB] != bus.a[MSB]);
            end
            OP_AND:  w_result = bus.a & bus.b;
            OP_OR:   w_result = bus.a | bus.b;
            OP_XOR:  w_result = bus.a ^ bus.b;
            OP_SLL:  w_result = bus.a << w_shamt;
            OP_SRL:  w_result = bus.a >> w_shamt;
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_lt};
            default: w_result = '0;
        endcase
    end

`ifdef ALU_FAULT_INJECT_EN
    logic [WIDTH-1:0] w_fault_mask;
    assign w_fault_mask = bus.fault_en ? ({{(WIDTH-1){1'b0}}, 1'b1} << bus.fault_bit) : '0;
    assign w_final      = w_result ^ w_fault_mask;
`else
    assign w_final = w_result;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_result <= w_final;
                r_zero   <= (w_final == '0);
                r_neg    <= w_final[MSB];
                r_carry  <= w_carry;
                r_ovf    <= w_ovf;
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.result     = r_result;
    assign bus.flag_zero  = r_zero;
    assign bus.flag_neg   = r_neg;
    assign bus.flag_carry = r_carry;
    assign bus.flag_ovf   = r_ovf;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] r;
    logic             z;
    logic             n;
    logic             c;
    logic             o;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  exp_t exp_q[$];
  exp_t last_out;

  alu_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  alu #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check_eq({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, e.v});
    check_eq({tag, ".result"}, bus.result, e.r);
    check_eq({tag, ".zero"}, {31'd0, bus.flag_zero}, {31'd0, e.z});
    check_eq({tag, ".neg"}, {31'd0, bus.flag_neg}, {31'd0, e.n});
    check_eq({tag, ".carry"}, {31'd0, bus.flag_carry}, {31'd0, e.c});
    check_eq({tag, ".ovf"}, {31'd0, bus.flag_ovf}, {31'd0, e.o});
  endtask

  // ---------------- reference model ----------------
  // Arithmetic done on 64-bit integers: carry/borrow and overflow come from
  // whether the true mathematical value fits the 32-bit range.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [2:0] op, input logic fen, input int fbit);
    exp_t   e;
    longint ua, ub, sa, sb, t;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e  = '0;
    e.v = 1'b1;
    case (op)
      3'd0: begin
        t   = ua + ub;
        e.r = t[31:0];
        e.c = (t > 64'sd4294967295);
        t   = sa + sb;
        e.o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'd1: begin
        t   = ua - ub;
        e.r = t[31:0];
        e.c = (ua < ub);
        t   = sa - sb;
        e.o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = a ^ b;
      3'd5: e.r = a << (ub % 32);
      3'd6: e.r = a >> (ub % 32);
      default: e.r = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    if (fen) e.r = e.r ^ (32'd1 << fbit);
    e.z = (e.r == 32'd0);
    e.n = e.r[31];
    return e;
  endfunction

  // ---------------- driver ----------------
  // At each falling edge: check what the previous edge produced, then drive
  // the next cycle's inputs and queue what the following edge must produce.
  task automatic step_f(input string tag, input logic v, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [2:0] op,
                        input logic fen, input int fbit);
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) check_outputs(tag, exp_q.pop_front());
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.opcode   = op;
`ifdef ALU_FAULT_INJECT_EN
    bus.fault_en  = fen;
    bus.fault_bit = fbit[SHAMT_W-1:0];
`endif
    if (v) begin
      e = model(a, b, op, fen, fbit);
      last_out = e;
    end else begin
      e   = last_out;
      e.v = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [2:0] op);
    step_f(tag, v, a, b, op, 1'b0, 0);
  endtask

  task automatic check_reset_zero(input string tag);
    exp_t z;
    z = '0;
    check_outputs(tag, z);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [2:0]       rop;
    tests_run    = 0;
    tests_failed = 0;
    last_out     = '0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.opcode   = '0;
`ifdef ALU_FAULT_INJECT_EN
    bus.fault_en  = 1'b0;
    bus.fault_bit = '0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // ADD corners
    step("add_wrap_in", 1'b1, 32'hFFFF_FFFF, 32'd1, 3'd0);
    step("add_wrap",    1'b1, 32'h7FFF_FFFF, 32'd1, 3'd0);
    // SUB / SLT
    step("add_ovf",     1'b1, 32'd5, 32'd7, 3'd1);
    step("sub_borrow",  1'b1, 32'hFFFF_FFFF, 32'd1, 3'd7);
    // logic / shift
    step("slt_neg",     1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'd4);
    step("xor",         1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'd2);
    step("and",         1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'd3);
    step("or",          1'b1, 32'h8000_0001, 32'h21, 3'd5);
    step("sll_upper_b", 1'b1, 32'h8000_0001, 32'd31, 3'd6);
    step("srl31",       1'b1, 32'hDEAD_BEEF, 32'h40, 3'd5);
    step("sll_zero",    1'b1, 32'h8000_0000, 32'h8000_0000, 3'd1);
    // back-to-back then idle hold
    step("sub_min",     1'b1, 32'd1, 32'd2, 3'd0);
    step("b2b_add",     1'b1, 32'd9, 32'd4, 3'd1);
    step("b2b_sub",     1'b1, 32'd3, 32'd3, 3'd4);
    step("b2b_xor",     1'b0, 32'd0, 32'd0, 3'd0);
    step("idle1",       1'b0, 32'h1234_5678, 32'h1, 3'd0);
    step("idle2",       1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 3'd7);

    // reset mid-stream with in_valid high: reset wins, outputs clear at once
    @(negedge clk);
    check_outputs("slt_pos", exp_q.pop_front());
    bus.in_valid = 1'b1;
    bus.a        = 32'd100;
    bus.b        = 32'd200;
    bus.opcode   = 3'd0;
    #2 rst_n = 1'b0;
    #1 check_reset_zero("rst_async");
    @(posedge clk);
    #1 check_reset_zero("rst_wins");
    exp_q.delete();
    last_out = '0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    exp_q.push_back('0);
    step("post_rst_idle", 1'b1, 32'd40, 32'd2, 3'd0);

`ifdef ALU_FAULT_INJECT_EN
    step_f("first_after_rst", 1'b1, 32'd0, 32'd0, 3'd0, 1'b1, 31);
    step_f("fault31",         1'b1, 32'hFFFF_FFFF, 32'd1, 3'd0, 1'b1, 0);
    step_f("fault0",          1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 5);
    step("fault_ignored_idle", 1'b1, 32'd7, 32'd7, 3'd1);
`endif

    // randomized traffic with occasional idle cycles
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 32'h7FFF_FFFF;
        1:       ra = 32'h8000_0000;
        2:       ra = $urandom_range(0, 3);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'hFFFF_FFFF;
        1:       rb = 32'h8000_0000;
        2:       rb = $urandom_range(0, 40);
        default: rb = $urandom;
      endcase
      rop = 3'($urandom_range(0, 7));
`ifdef ALU_FAULT_INJECT_EN
      step_f("rand", ($urandom_range(0, 4) != 0), ra, rb, rop,
             ($urandom_range(0, 3) == 0), int'($urandom_range(0, 31)));
`else
      step("rand", ($urandom_range(0, 4) != 0), ra, rb, rop);
`endif
    end
    step("drain", 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    check_outputs("final", exp_q.pop_front());

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
